seq_control_unit: RTL and testbench

Parametrised multi-cycle control unit for the bitty processor datapath. It is the successor to the current control FSM. It latches the instruction on run and sequences S-load, ALU/load-store execute and register writeback. New over the prior unit: a configurable register count and data width, an illegal-register trap, a load/store timeout with a sticky error, and a retired-instruction counter.

---
 rtl/seq_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_seq_control_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_control_unit.sv
// Multi-cycle sequencer for the bitty datapath: latches an instruction on run and steps it
// through S-load, execute and writeback, trapping on illegal registers or a load/store timeout.
module seq_control_unit #(
    parameter int DATA_W     = 16,
    parameter int NUM_REGS   = 8,
    parameter int IMM_SIGNED = 0,
    parameter int LS_TIMEOUT = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [15:0]                   instruction,
    input  logic                          ls_done,
    output logic [$clog2(NUM_REGS+2)-1:0] mux_sel,
    output logic [2:0]                    sel,
    output logic                          sel_reg_c,
    output logic                          en_s,
    output logic                          en_c,
    output logic [1:0]                    en_ls,
    output logic [NUM_REGS-1:0]           en,
    output logic                          en_inst,
    output logic [DATA_W-1:0]             immediate,
    output logic                          done,
    output logic                          busy,
    output logic                          err,
    output logic [CNT_W-1:0]              instr_count
);

    localparam int MW  = $clog2(NUM_REGS + 2);
    localparam int WCW = (LS_TIMEOUT > 1) ? $clog2(LS_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((LS_TIMEOUT > 0) ? LS_TIMEOUT - 1 : 0);

    localparam logic [1:0] FMT_ALU_REG = 2'b00;
    localparam logic [1:0] FMT_ALU_IMM = 2'b01;
    localparam logic [1:0] FMT_NOP     = 2'b10;
    localparam logic [1:0] FMT_LS      = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_S,
        EXEC,
        WB,
        ERR
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [15:0]    ir;
    logic [WCW-1:0] wait_cnt;

    logic [1:0]     ir_fmt;
    logic           ir_ls;
    logic [2:0]     ir_src;
    logic [2:0]     ir_dst;
    logic [7:0]     ir_imm8;
    logic [1:0]     in_fmt;
    logic [2:0]     in_src;
    logic [2:0]     in_dst;
    logic           accept_illegal;
    logic           timeout_hit;
    logic           writes_reg;

    assign ir_fmt  = ir[1:0];
    assign ir_ls   = ir[2];
    assign ir_src  = ir[12:10];
    assign ir_dst  = ir[15:13];
    assign ir_imm8 = ir[12:5];
    assign in_fmt  = instruction[1:0];
    assign in_src  = instruction[12:10];
    assign in_dst  = instruction[15:13];

    // Register fields are only checked where the format actually reads or writes them.
    always_comb begin
        accept_illegal = 1'b0;
        if ((in_fmt == FMT_ALU_REG || in_fmt == FMT_ALU_IMM ||
             (in_fmt == FMT_LS && !instruction[2])) && (int'(in_dst) >= NUM_REGS))
            accept_illegal = 1'b1;
        if ((in_fmt == FMT_ALU_REG || in_fmt == FMT_LS) && (int'(in_src) >= NUM_REGS))
            accept_illegal = 1'b1;
    end

    assign timeout_hit = (LS_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    assign writes_reg  = (ir_fmt == FMT_ALU_REG) || (ir_fmt == FMT_ALU_IMM) ||
                         (ir_fmt == FMT_LS && !ir_ls);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ir          <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && run)
                ir <= instruction;
            if (state == LOAD_S)
                wait_cnt <= '0;
            else if (state == EXEC && ir_fmt == FMT_LS && !ls_done)
                wait_cnt <= wait_cnt + WCW'(1);
            if (state == WB)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (run) begin
                    if (accept_illegal)
                        state_nxt = ERR;
                    else if (in_fmt == FMT_NOP)
                        state_nxt = WB;
                    else
                        state_nxt = LOAD_S;
                end
            end
            LOAD_S: state_nxt = EXEC;
            EXEC: begin
                if (ir_fmt != FMT_LS || ls_done)
                    state_nxt = WB;
                else if (timeout_hit)
                    state_nxt = ERR;
            end
            WB:      state_nxt = IDLE;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mux_sel   = MW'(NUM_REGS + 1);
        sel       = 3'b000;
        sel_reg_c = 1'b0;
        en_s      = 1'b0;
        en_c      = 1'b0;
        en_ls     = 2'b00;
        en        = '0;
        en_inst   = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: en_inst = 1'b1;
            LOAD_S: begin
                en_s    = 1'b1;
                mux_sel = MW'(ir_dst);
                busy    = 1'b1;
            end
            EXEC: begin
                busy    = 1'b1;
                en_c    = 1'b1;
                sel     = ir[4:2];
                mux_sel = (ir_fmt == FMT_ALU_IMM) ? MW'(NUM_REGS) : MW'(ir_src);
                if (ir_fmt == FMT_LS) begin
                    sel_reg_c = 1'b1;
                    en_ls     = ir_ls ? 2'b10 : 2'b01;
                end
            end
            WB: begin
                done    = 1'b1;
                en_inst = 1'b1;
                busy    = 1'b1;
                if (writes_reg)
                    en = NUM_REGS'(1) << ir_dst;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        if (IMM_SIGNED != 0)
            immediate = DATA_W'($signed(ir_imm8));
        else
            immediate = DATA_W'(ir_imm8);
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: two instances (8 regs signed-imm with LS timeout 4, and 4 regs
// zero-imm with 2-bit counter) checked cycle by cycle against a timeline model of the sequencer.
module tb_seq_control_unit;

    localparam int PH_IDLE   = 0;
    localparam int PH_SLOAD  = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_RETIRE = 3;
    localparam int PH_TRAP   = 4;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_run, a_ls_done;
    logic [15:0] a_instr;
    logic [3:0]  a_mux_sel;
    logic [2:0]  a_sel;
    logic        a_sel_reg_c, a_en_s, a_en_c, a_en_inst, a_done, a_busy, a_err;
    logic [1:0]  a_en_ls;
    logic [7:0]  a_en;
    logic [15:0] a_imm;
    logic [15:0] a_cnt;

    logic        b_run, b_ls_done;
    logic [15:0] b_instr;
    logic [2:0]  b_mux_sel;
    logic [2:0]  b_sel;
    logic        b_sel_reg_c, b_en_s, b_en_c, b_en_inst, b_done, b_busy, b_err;
    logic [1:0]  b_en_ls;
    logic [3:0]  b_en;
    logic [15:0] b_imm;
    logic [1:0]  b_cnt;

    int checks = 0;
    int passes = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    always #5 clk = ~clk;

    seq_control_unit #(
        .DATA_W(16), .NUM_REGS(8), .IMM_SIGNED(1), .LS_TIMEOUT(4), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .reset(reset), .run(a_run), .instruction(a_instr), .ls_done(a_ls_done),
        .mux_sel(a_mux_sel), .sel(a_sel), .sel_reg_c(a_sel_reg_c), .en_s(a_en_s),
        .en_c(a_en_c), .en_ls(a_en_ls), .en(a_en), .en_inst(a_en_inst),
        .immediate(a_imm), .done(a_done), .busy(a_busy), .err(a_err), .instr_count(a_cnt)
    );

    seq_control_unit #(
        .DATA_W(16), .NUM_REGS(4), .IMM_SIGNED(0), .LS_TIMEOUT(0), .CNT_W(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .run(b_run), .instruction(b_instr), .ls_done(b_ls_done),
        .mux_sel(b_mux_sel), .sel(b_sel), .sel_reg_c(b_sel_reg_c), .en_s(b_en_s),
        .en_c(b_en_c), .en_ls(b_en_ls), .en(b_en), .en_inst(b_en_inst),
        .immediate(b_imm), .done(b_done), .busy(b_busy), .err(b_err), .instr_count(b_cnt)
    );

    function automatic logic [23:0] cur_vec(input bit use_b);
        if (use_b)
            return {1'b0, b_mux_sel, b_sel, b_sel_reg_c, b_en_s, b_en_c, b_en_ls, 4'b0000,
                    b_en, b_en_inst, b_done, b_busy, b_err};
        return {a_mux_sel, a_sel, a_sel_reg_c, a_en_s, a_en_c, a_en_ls, a_en,
                a_en_inst, a_done, a_busy, a_err};
    endfunction

    function automatic int cur_cnt(input bit use_b);
        return use_b ? int'(b_cnt) : int'(a_cnt);
    endfunction

    function automatic int exp_cnt(input bit use_b);
        return use_b ? (exp_cnt_b % 4) : (exp_cnt_a % 65536);
    endfunction

    function automatic logic [15:0] cur_imm(input bit use_b);
        return use_b ? b_imm : a_imm;
    endfunction

    function automatic logic [15:0] expect_imm(input bit use_b, input logic [15:0] ins);
        logic [7:0] imm8 = ins[12:5];
        return use_b ? {8'h00, imm8} : {{8{imm8[7]}}, imm8};
    endfunction

    function automatic bit is_illegal(input int nr, input logic [15:0] ins);
        int  fmt = int'(ins[1:0]);
        bit  dst_used = (fmt == 0) || (fmt == 1) || (fmt == 3 && !ins[2]);
        bit  src_used = (fmt == 0) || (fmt == 3);
        return (dst_used && int'(ins[15:13]) >= nr) || (src_used && int'(ins[12:10]) >= nr);
    endfunction

    // Expected control outputs for one phase of an instruction's life, from the behavioural rules.
    function automatic logic [23:0] expect_vec(input int nr, input int phase, input logic [15:0] ins);
        int         fmt = int'(ins[1:0]);
        logic [3:0] mux = 4'(nr + 1);
        logic [2:0] sl  = 3'b000;
        logic       rc = 0, es = 0, ec = 0, ei = 0, dn = 0, bs = 0, er = 0;
        logic [1:0] els = 2'b00;
        logic [7:0] en  = 8'h00;
        case (phase)
            PH_IDLE:  ei = 1;
            PH_SLOAD: begin mux = {1'b0, ins[15:13]}; es = 1; bs = 1; end
            PH_EXEC: begin
                bs = 1; ec = 1; sl = ins[4:2];
                mux = (fmt == 1) ? 4'(nr) : {1'b0, ins[12:10]};
                if (fmt == 3) begin rc = 1; els = ins[2] ? 2'b10 : 2'b01; end
            end
            PH_RETIRE: begin
                dn = 1; ei = 1; bs = 1;
                if (fmt == 0 || fmt == 1 || (fmt == 3 && !ins[2]))
                    en = 8'd1 << ins[15:13];
            end
            PH_TRAP: er = 1;
            default: ;
        endcase
        return {mux, sl, rc, es, ec, els, en, ei, dn, bs, er};
    endfunction

    task automatic set_run(input bit use_b, input logic r, input logic [15:0] ins);
        if (use_b) begin b_run = r; b_instr = ins; end
        else begin a_run = r; a_instr = ins; end
    endtask

    task automatic set_ls(input bit use_b, input logic v);
        if (use_b) b_ls_done = v; else a_ls_done = v;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    // Runs one instruction from IDLE to retire (or trap); k = extra EXEC cycles before ls_done.
    task automatic issue(input bit use_b, input logic [15:0] ins, input int k);
        int nr    = use_b ? 4 : 8;
        int fmt   = int'(ins[1:0]);
        int nexec = (fmt == 3) ? k : 0;
        checks++;
        if (cur_vec(use_b) !== expect_vec(nr, PH_IDLE, ins))
            $display("[TB] FAIL idle_outputs: got %h want %h", cur_vec(use_b), expect_vec(nr, PH_IDLE, ins));
        else passes++;
        set_run(use_b, 1'b1, ins);
        @(negedge clk);
        set_run(use_b, 1'b0, 16'($urandom));
        if (is_illegal(nr, ins)) begin
            checks++;
            if (cur_vec(use_b) !== expect_vec(nr, PH_TRAP, ins))
                $display("[TB] FAIL trap_outputs: got %h want %h", cur_vec(use_b), expect_vec(nr, PH_TRAP, ins));
            else passes++;
            @(negedge clk);
            checks++;
            if (cur_cnt(use_b) !== exp_cnt(use_b))
                $display("[TB] FAIL trap_count: got %0d want %0d", cur_cnt(use_b), exp_cnt(use_b));
            else passes++;
            return;
        end
        if (fmt != 2) begin
            checks++;
            if (cur_vec(use_b) !== expect_vec(nr, PH_SLOAD, ins))
                $display("[TB] FAIL sload_outputs: got %h want %h", cur_vec(use_b), expect_vec(nr, PH_SLOAD, ins));
            else passes++;
            checks++;
            if (cur_imm(use_b) !== expect_imm(use_b, ins))
                $display("[TB] FAIL immediate: got %h want %h", cur_imm(use_b), expect_imm(use_b, ins));
            else passes++;
            for (int j = 0; j <= nexec; j++) begin
                @(negedge clk);
                checks++;
                if (cur_vec(use_b) !== expect_vec(nr, PH_EXEC, ins))
                    $display("[TB] FAIL exec_outputs: got %h want %h", cur_vec(use_b), expect_vec(nr, PH_EXEC, ins));
                else passes++;
                if (fmt == 3 && j == nexec)
                    set_ls(use_b, 1'b1);
            end
            @(negedge clk);
            set_ls(use_b, 1'b0);
        end
        checks++;
        if (cur_vec(use_b) !== expect_vec(nr, PH_RETIRE, ins))
            $display("[TB] FAIL retire_outputs: got %h want %h", cur_vec(use_b), expect_vec(nr, PH_RETIRE, ins));
        else passes++;
        if (use_b) exp_cnt_b++; else exp_cnt_a++;
        @(negedge clk);
        checks++;
        if (cur_cnt(use_b) !== exp_cnt(use_b))
            $display("[TB] FAIL instr_count: got %0d want %0d", cur_cnt(use_b), exp_cnt(use_b));
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cur_vec(0) !== expect_vec(8, PH_IDLE, 16'h0))
            $display("[TB] FAIL reset_outputs_a: got %h want %h", cur_vec(0), expect_vec(8, PH_IDLE, 16'h0));
        else passes++;
        checks++;
        if (cur_vec(1) !== expect_vec(4, PH_IDLE, 16'h0))
            $display("[TB] FAIL reset_outputs_b: got %h want %h", cur_vec(1), expect_vec(4, PH_IDLE, 16'h0));
        else passes++;
        checks++;
        if ({a_cnt, a_imm, b_cnt, b_imm} !== 50'h0)
            $display("[TB] FAIL reset_count_imm: got %h want 0", {a_cnt, a_imm, b_cnt, b_imm});
        else passes++;
        reset = 1'b1;
    endtask

    task automatic test_directed();
        issue(0, 16'b010_001_0000_000_1_00, 0);
        issue(0, {3'd3, 8'hF0, 3'b010, 2'b01}, 0);
        issue(1, {3'd3, 8'hF0, 3'b010, 2'b01}, 0);
        issue(0, {3'd5, 3'd3, 5'd0, 2'b00, 1'b0, 2'b11}, 2);
        issue(0, {3'd2, 3'd4, 5'd9, 2'b10, 1'b1, 2'b11}, 1);
        issue(0, 16'hE002, 0);
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int i = 0; i < 24; i++) begin
            ins = 16'($urandom);
            issue(0, ins, int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 8; i++) begin
            ins = 16'($urandom);
            while (is_illegal(4, ins)) ins = 16'($urandom);
            issue(1, ins, int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] nop = 16'h2002;
        logic [15:0] alu = {3'd6, 3'd7, 5'd3, 3'b101, 2'b00};
        a_run = 1'b1; a_instr = nop;
        @(negedge clk);
        checks++;
        if (cur_vec(0) !== expect_vec(8, PH_RETIRE, nop))
            $display("[TB] FAIL b2b_nop_retire: got %h want %h", cur_vec(0), expect_vec(8, PH_RETIRE, nop));
        else passes++;
        exp_cnt_a++;
        a_instr = alu;
        @(negedge clk);
        checks++;
        if ({cur_vec(0), a_cnt} !== {expect_vec(8, PH_IDLE, alu), 16'(exp_cnt_a)})
            $display("[TB] FAIL b2b_idle_gap: got %h want %h", {cur_vec(0), a_cnt}, {expect_vec(8, PH_IDLE, alu), 16'(exp_cnt_a)});
        else passes++;
        @(negedge clk);
        a_run = 1'b0;
        checks++;
        if (cur_vec(0) !== expect_vec(8, PH_SLOAD, alu))
            $display("[TB] FAIL b2b_second_sload: got %h want %h", cur_vec(0), expect_vec(8, PH_SLOAD, alu));
        else passes++;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cur_vec(0) !== expect_vec(8, PH_RETIRE, alu))
            $display("[TB] FAIL b2b_second_retire: got %h want %h", cur_vec(0), expect_vec(8, PH_RETIRE, alu));
        else passes++;
        exp_cnt_a++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [15:0] st = {3'd4, 3'd2, 5'b10101, 2'b01, 1'b1, 2'b11};
        a_run = 1'b1; a_instr = st; a_ls_done = 1'b0;
        @(negedge clk);
        a_run = 1'b0;
        checks++;
        if (cur_vec(0) !== expect_vec(8, PH_SLOAD, st))
            $display("[TB] FAIL timeout_sload: got %h want %h", cur_vec(0), expect_vec(8, PH_SLOAD, st));
        else passes++;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (cur_vec(0) !== expect_vec(8, PH_EXEC, st))
                $display("[TB] FAIL timeout_exec_wait: got %h want %h", cur_vec(0), expect_vec(8, PH_EXEC, st));
            else passes++;
        end
        a_run = 1'b1; a_instr = 16'h4404;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (cur_vec(0) !== expect_vec(8, PH_TRAP, st))
                $display("[TB] FAIL timeout_err_sticky: got %h want %h", cur_vec(0), expect_vec(8, PH_TRAP, st));
            else passes++;
        end
        a_run = 1'b0;
        checks++;
        if (cur_cnt(0) !== exp_cnt(0))
            $display("[TB] FAIL timeout_count: got %0d want %0d", cur_cnt(0), exp_cnt(0));
        else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (cur_vec(0) !== expect_vec(8, PH_IDLE, st))
            $display("[TB] FAIL timeout_reset_clears: got %h want %h", cur_vec(0), expect_vec(8, PH_IDLE, st));
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    task automatic test_illegal();
        reset_pulse();
        issue(1, {3'd6, 3'd1, 5'd0, 3'b000, 2'b00}, 0);
        reset_pulse();
        issue(1, {3'd1, 3'd5, 5'd0, 2'b00, 1'b0, 2'b11}, 0);
        reset_pulse();
        issue(1, {3'd6, 3'd2, 5'd0, 2'b00, 1'b1, 2'b11}, 1);
        issue(1, {3'd7, 3'd7, 8'h00, 2'b10}, 0);
    endtask

    task automatic test_async_reset();
        logic [15:0] ld = {3'd3, 3'd1, 5'd0, 2'b11, 1'b0, 2'b11};
        a_run = 1'b1; a_instr = ld; a_ls_done = 1'b0;
        @(negedge clk);
        a_run = 1'b0;
        @(negedge clk);
        checks++;
        if (cur_vec(0) !== expect_vec(8, PH_EXEC, ld))
            $display("[TB] FAIL async_pre_exec: got %h want %h", cur_vec(0), expect_vec(8, PH_EXEC, ld));
        else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (cur_vec(0) !== expect_vec(8, PH_IDLE, ld))
            $display("[TB] FAIL async_reset_exec: got %h want %h", cur_vec(0), expect_vec(8, PH_IDLE, ld));
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    task automatic test_count_wrap();
        reset_pulse();
        for (int i = 0; i < 5; i++)
            issue(1, 16'h0002, 0);
        checks++;
        if (b_cnt !== 2'd1)
            $display("[TB] FAIL count_wrap: got %0d want 1", b_cnt);
        else passes++;
    endtask

    initial begin
        reset = 1'b0;
        a_run = 1'b0; a_instr = 16'h0; a_ls_done = 1'b0;
        b_run = 1'b0; b_instr = 16'h0; b_ls_done = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_async_reset();
        test_count_wrap();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
